move_arbiter: RTL and testbench



---
 rtl/tetris_pkg.sv | 20 ++
 rtl/button_conditioner.sv | 81 ++++++++
 rtl/move_arbiter.sv | 147 ++++++++++++++
 tb/tb_move_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris movement path:
// move intent encodings and the arbiter state encoding.
package tetris_pkg;

    localparam logic [1:0] INTENT_DOWN  = 2'b00;
    localparam logic [1:0] INTENT_LEFT  = 2'b01;
    localparam logic [1:0] INTENT_RIGHT = 2'b10;
    localparam logic [1:0] INTENT_ROT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        GAP  = 2'b10
    } move_state_e;

    function automatic logic [1:0] lr_intent(input logic pick_right);
        return pick_right ? INTENT_RIGHT : INTENT_LEFT;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button to event pulse: 2-flop synchroniser, debounce,
// rising-edge detect and optional hold-to-repeat.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_RATE     = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic butt,
    output logic event_o
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_phase_q, rep_phase_d;
    logic          event_q, event_d;
    logic          rise;
    logic          rep_fire;

    always_comb begin
        sync1_d     = butt;
        sync2_d     = sync1_q;
        db_d        = db_q;
        db_cnt_d    = '0;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_fire    = 1'b0;
        // Any return to the accepted level restarts the stability count.
        if (sync2_q != db_q) begin
            if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        rise = db_d & ~db_q;
        if (REPEAT_EN && db_q) begin
            rep_phase_d = rep_phase_q;
            rep_cnt_d   = rep_cnt_q + 1'b1;
            if (rep_cnt_q == (rep_phase_q ? RW'(REPEAT_RATE - 1)
                                          : RW'(REPEAT_DELAY - 1))) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_phase_d = 1'b1;
            end
        end
        event_d = rise | rep_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_q        <= 1'b0;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            event_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            event_q     <= event_d;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/move_arbiter.sv
// Shares the single movement handshake between gravity and three buttons,
// one request in flight, fixed priority with left/right alternation.
module move_arbiter
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_RATE     = 2000000,
    parameter int ACK_TIMEOUT     = 1024
) (
    input  logic       clk_25_175,
    input  logic       reset,
    input  logic       gametick,
    input  logic       buttL,
    input  logic       buttT,
    input  logic       buttR,
    input  logic       movement_commit,
    input  logic       movement_declined,
    output logic       movement_request,
    output logic [1:0] movement_intent,
    output logic       timeout_pulse,
    output logic       tick_overrun
);

    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    logic ev_left, ev_right, ev_rot;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) u_left (.clk(clk_25_175), .rst(reset), .butt(buttL), .event_o(ev_left));

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) u_right (.clk(clk_25_175), .rst(reset), .butt(buttR), .event_o(ev_right));

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) u_rot (.clk(clk_25_175), .rst(reset), .butt(buttT), .event_o(ev_rot));

    move_state_e   state_q, state_d;
    logic          pend_down_q, pend_down_d;
    logic          pend_rot_q, pend_rot_d;
    logic          pend_left_q, pend_left_d;
    logic          pend_right_q, pend_right_d;
    logic          rr_q, rr_d;
    logic [1:0]    intent_q, intent_d;
    logic          req_q, req_d;
    logic          tout_q, tout_d;
    logic          ovr_q, ovr_d;
    logic [AW-1:0] wait_q, wait_d;
    logic          clr_down, clr_rot, clr_left, clr_right;
    logic          pick_right;

    always_comb begin
        state_d    = state_q;
        intent_d   = intent_q;
        req_d      = req_q;
        tout_d     = 1'b0;
        rr_d       = rr_q;
        wait_d     = wait_q;
        clr_down   = 1'b0;
        clr_rot    = 1'b0;
        clr_left   = 1'b0;
        clr_right  = 1'b0;
        pick_right = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_down_q) begin
                    intent_d = INTENT_DOWN;
                    clr_down = 1'b1;
                end else if (pend_rot_q) begin
                    intent_d = INTENT_ROT;
                    clr_rot  = 1'b1;
                end else if (pend_left_q || pend_right_q) begin
                    pick_right = pend_right_q && (!pend_left_q || rr_q);
                    intent_d   = lr_intent(pick_right);
                    clr_left   = !pick_right;
                    clr_right  = pick_right;
                    rr_d       = ~rr_q;
                end
                if (pend_down_q || pend_rot_q || pend_left_q || pend_right_q) begin
                    req_d   = 1'b1;
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (movement_commit || movement_declined) begin
                    req_d   = 1'b0;
                    state_d = GAP;
                end else if (wait_q == AW'(ACK_TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    tout_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new event in the issuing cycle wins over the clear.
        pend_down_d  = gametick | (pend_down_q & ~clr_down);
        pend_rot_d   = ev_rot   | (pend_rot_q & ~clr_rot);
        pend_left_d  = ev_left  | (pend_left_q & ~clr_left);
        pend_right_d = ev_right | (pend_right_q & ~clr_right);
        ovr_d        = ovr_q | (gametick & pend_down_q & ~clr_down);
    end

    always_ff @(posedge clk_25_175 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_down_q  <= 1'b0;
            pend_rot_q   <= 1'b0;
            pend_left_q  <= 1'b0;
            pend_right_q <= 1'b0;
            rr_q         <= 1'b0;
            intent_q     <= INTENT_DOWN;
            req_q        <= 1'b0;
            tout_q       <= 1'b0;
            ovr_q        <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_down_q  <= pend_down_d;
            pend_rot_q   <= pend_rot_d;
            pend_left_q  <= pend_left_d;
            pend_right_q <= pend_right_d;
            rr_q         <= rr_d;
            intent_q     <= intent_d;
            req_q        <= req_d;
            tout_q       <= tout_d;
            ovr_q        <= ovr_d;
            wait_q       <= wait_d;
        end
    end

    assign movement_request = req_q;
    assign movement_intent  = intent_q;
    assign timeout_pulse    = tout_q;
    assign tick_overrun     = ovr_q;

endmodule

// File: tb/tb_move_arbiter.sv
// Scoreboard bench for move_arbiter: stimulus pushes expected intents,
// a monitor pops them on every request rise.
module tb_move_arbiter;
    import tetris_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       gametick = 1'b0;
    logic       buttL = 1'b0, buttT = 1'b0, buttR = 1'b0;
    logic       commit = 1'b0, declined = 1'b0;
    logic       req;
    logic [1:0] intent;
    logic       tp, ovr;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [1:0] exp_q[$];
    int         rise_q[$];
    int         last_rise = 0, last_fall = 0, tp_cnt = 0;
    bit         ack_en = 1'b1;
    int         ack_dly = 3;
    int         ack_kind = 0;
    int         commit_cyc = 0;
    bit         rr_m = 1'b0;
    bit         mprev = 1'b0, rprev = 1'b0;
    logic [1:0] held = 2'b00;

    move_arbiter #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20),
        .REPEAT_RATE(8), .ACK_TIMEOUT(16)
    ) dut (
        .clk_25_175(clk), .reset(reset), .gametick(gametick),
        .buttL(buttL), .buttT(buttT), .buttR(buttR),
        .movement_commit(commit), .movement_declined(declined),
        .movement_request(req), .movement_intent(intent),
        .timeout_pulse(tp), .tick_overrun(ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each request rise.
    initial begin
        forever begin
            @(negedge clk);
            if (tp) tp_cnt++;
            if (!reset) begin
                if (req && !mprev) begin
                    rise_q.push_back(cyc);
                    last_rise = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_request: intent=%0d none expected", intent);
                    end else begin
                        chk("issue_intent", int'(intent), int'(exp_q.pop_front()));
                    end
                    held = intent;
                end else if (req) begin
                    chk("intent_stable", int'(intent), int'(held));
                end
                if (!req && mprev) last_fall = cyc;
            end
            mprev = reset ? 1'b0 : req;
        end
    end

    // Responder: acknowledges each request after ack_dly cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && req && !rprev && ack_en) begin
                for (int i = 1; i < ack_dly && req; i++) @(negedge clk);
                if (req && !reset) begin
                    commit     = (ack_kind != 1);
                    declined   = (ack_kind != 0);
                    commit_cyc = cyc;
                    @(negedge clk);
                    commit   = 1'b0;
                    declined = 1'b0;
                end
            end
            rprev = req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || req) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d requests still expected", exp_q.size());
            exp_q.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    // Make the chosen sources pending in one IDLE cycle; order from priority rules.
    task automatic trial(input bit d, input bit t, input bit l, input bit r);
        if (d) exp_q.push_back(INTENT_DOWN);
        if (t) exp_q.push_back(INTENT_ROT);
        if (l && r) begin
            exp_q.push_back(rr_m ? INTENT_RIGHT : INTENT_LEFT);
            exp_q.push_back(rr_m ? INTENT_LEFT : INTENT_RIGHT);
        end else if (l || r) begin
            exp_q.push_back(l ? INTENT_LEFT : INTENT_RIGHT);
            rr_m = !rr_m;
        end
        @(negedge clk);
        buttT = t;
        buttL = l;
        buttR = r;
        repeat (6) @(negedge clk);
        gametick = d;
        @(negedge clk);
        gametick = 1'b0;
        repeat (3) @(negedge clk);
        buttT = 1'b0;
        buttL = 1'b0;
        buttR = 1'b0;
        drain(300);
    endtask

    initial begin
        int tick_cyc, stable_cyc, n;
        bit [3:0] m;
        repeat (3) @(negedge clk);
        chk("reset_request", req, 0);
        chk("reset_intent", int'(intent), 0);
        chk("reset_timeout", tp, 0);
        chk("reset_overrun", ovr, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single gametick, commit three cycles in.
        ack_dly = 3;
        ack_kind = 0;
        exp_q.push_back(INTENT_DOWN);
        gametick = 1'b1;
        tick_cyc = cyc;
        @(negedge clk);
        gametick = 1'b0;
        drain(100);
        chk("tick_to_request", last_rise - tick_cyc, 2);
        chk("commit_to_drop", last_fall - commit_cyc, 1);
        chk("overrun_single", ovr, 0);

        // Bouncy left press held 40 cycles: edge plus three repeats.
        rise_q.delete();
        repeat (4) exp_q.push_back(INTENT_LEFT);
        buttL = 1'b1;
        @(negedge clk);
        buttL = 1'b0;
        @(negedge clk);
        buttL = 1'b1;
        stable_cyc = cyc;
        repeat (40) @(negedge clk);
        buttL = 1'b0;
        drain(200);
        chk("repeat_count", rise_q.size(), 4);
        if (rise_q.size() == 4) begin
            chk("first_press_latency", rise_q[0] - stable_cyc, 8);
            chk("repeat_delay", rise_q[1] - rise_q[0], 20);
            chk("repeat_rate_1", rise_q[2] - rise_q[1], 8);
            chk("repeat_rate_2", rise_q[3] - rise_q[2], 8);
        end

        // Down, rotate, left pending together.
        trial(1'b1, 1'b1, 1'b1, 1'b0);

        // No ack: timeout, then the rotate queued meanwhile.
        ack_en = 1'b0;
        tp_cnt = 0;
        exp_q.push_back(INTENT_DOWN);
        exp_q.push_back(INTENT_ROT);
        gametick = 1'b1;
        @(negedge clk);
        gametick = 1'b0;
        @(negedge clk);
        buttT = 1'b1;
        repeat (10) @(negedge clk);
        buttT = 1'b0;
        n = 0;
        while (req && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ack_en = 1'b1;
        chk("timeout_high_len", last_fall - last_rise, 16);
        drain(100);
        chk("timeout_pulses", tp_cnt, 1);

        // Two ticks during REQ merge into one down; then reset mid-request.
        ack_dly = 10;
        rise_q.delete();
        exp_q.push_back(INTENT_DOWN);
        exp_q.push_back(INTENT_DOWN);
        gametick = 1'b1;
        @(negedge clk);
        gametick = 1'b0;
        repeat (2) @(negedge clk);
        gametick = 1'b1;
        @(negedge clk);
        gametick = 1'b0;
        @(negedge clk);
        gametick = 1'b1;
        @(negedge clk);
        gametick = 1'b0;
        n = 0;
        while (rise_q.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("merged_down_issued", rise_q.size(), 2);
        chk("overrun_set", ovr, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_request", req, 0);
        chk("async_reset_overrun", ovr, 0);
        exp_q.delete();
        rr_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Left and right together twice: alternation.
        ack_dly = 2;
        trial(1'b0, 1'b0, 1'b1, 1'b1);
        trial(1'b0, 1'b0, 1'b1, 1'b1);

        // Random source mixes and ack styles.
        for (int k = 0; k < 16; k++) begin
            m = 4'($urandom_range(1, 15));
            ack_dly = $urandom_range(1, 6);
            ack_kind = $urandom_range(0, 2);
            trial(m[0], m[1], m[2], m[3]);
        end

        chk("final_overrun", ovr, 0);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
